fdd_head_sequencer: RTL and testbench

- Per-drive head/motor state controller for the four emulated drive slots.
- Tracks the cylinder position of each enabled slot from the host STEP/DIR pulses, latches motor state the way the Amiga does (on select falling edge), and produces TRK0 and INDEX for the emulated drives.
- Sequences track-load requests to the microcontroller through a valid/ack handshake once head motion has settled.
- Sits between the synchronised host floppy bus and the uC. Its trk0/index outputs feed the emulator output muxing in place of external per-drive sources.

---
 rtl/fdd_pkg.sv | 29 ++
 rtl/fdd_sync_edge.sv | 35 +++
 rtl/fdd_head_sequencer.sv | 224 ++++++++++++++++++++++
 tb/tb_fdd_head_sequencer.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fdd_pkg.sv
// Shared constants, FSM state encoding and helpers for the floppy head sequencer.
package fdd_pkg;

    localparam int NUM_DRIVES = 4;
    localparam int CYL_W      = 7;

    // Default timing for a 20 MHz xclk
    localparam int DEF_MAX_CYL       = 83;
    localparam int DEF_INDEX_PERIOD  = 4000000;
    localparam int DEF_INDEX_WIDTH   = 40000;
    localparam int DEF_SETTLE_CYCLES = 300000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        REQ    = 2'd2
    } fdd_state_e;

    // Lowest-numbered slot set in the mask (0 when the mask is empty)
    function automatic logic [1:0] first_active(input logic [NUM_DRIVES-1:0] mask);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = NUM_DRIVES - 1; i >= 0; i--) begin
            if (mask[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/fdd_sync_edge.sv
// Two-flop synchroniser for one asynchronous host/uC line, with edge strobes
// taken between the second stage and a third registered copy.
module fdd_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic xclk,
    input  logic rst,
    input  logic i_d,
    output logic o_q,
    output logic o_rise,
    output logic o_fall
);

    logic r_s1;
    logic r_s2;
    logic r_s3;

    // Synchroniser chain plus delayed copy for edge detection
    always_ff @(posedge xclk or posedge rst) begin
        if (rst) begin
            r_s1 <= RST_VAL;
            r_s2 <= RST_VAL;
            r_s3 <= RST_VAL;
        end else begin
            r_s1 <= i_d;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign o_q    = r_s2;
    assign o_rise = r_s2 & ~r_s3;
    assign o_fall = ~r_s2 & r_s3;

endmodule

// File: rtl/fdd_head_sequencer.sv
// Per-slot head position, motor latch, TRK0/INDEX generation and track-load
// request sequencing for the four emulated floppy drive slots.
//
// state  | meaning
// IDLE   | no head activity pending
// SETTLE | head moved recently; waiting for the settle timer to expire
// REQ    | request presented to the uC, waiting for req_ack
module fdd_head_sequencer
    import fdd_pkg::*;
#(
    parameter int MAX_CYL       = DEF_MAX_CYL,
    parameter int INDEX_PERIOD  = DEF_INDEX_PERIOD,
    parameter int INDEX_WIDTH   = DEF_INDEX_WIDTH,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
    input  logic                  xclk,
    input  logic                  rst,
    input  logic [NUM_DRIVES-1:0] sel_n,
    input  logic [NUM_DRIVES-1:0] ena,
    input  logic                  mtr_n,
    input  logic                  dir,
    input  logic                  step_n,
    input  logic                  side,
    output logic [NUM_DRIVES-1:0] trk0_n,
    output logic [NUM_DRIVES-1:0] mtr_on,
    output logic                  index_n,
    output logic                  req_valid,
    output logic [1:0]            req_drive,
    output logic [CYL_W-1:0]      req_cyl,
    output logic                  req_side,
    input  logic                  req_ack
);

    localparam logic [1:0] S_IDLE   = IDLE;
    localparam logic [1:0] S_SETTLE = SETTLE;
    localparam logic [1:0] S_REQ    = REQ;

    localparam logic [CYL_W-1:0] L_MAX_CYL   = CYL_W'(MAX_CYL);
    localparam logic [31:0]      L_SETTLE    = 32'(SETTLE_CYCLES);
    localparam logic [31:0]      L_IDX_LAST  = 32'(INDEX_PERIOD - 1);
    localparam logic [31:0]      L_IDX_WIDTH = 32'(INDEX_WIDTH);

    logic [NUM_DRIVES-1:0] w_sel_q, w_sel_rise, w_sel_fall;
    logic [NUM_DRIVES-1:0] w_ena_q, w_ena_rise, w_ena_fall;
    logic w_mtr_n_q, w_mtr_n_rise, w_mtr_n_fall;
    logic w_dir_q, w_dir_rise, w_dir_fall;
    logic w_step_q, w_step_rise, w_step_fall;
    logic w_side_q, w_side_rise, w_side_fall;

    for (genvar g = 0; g < NUM_DRIVES; g++) begin : g_slot_sync
        fdd_sync_edge #(.RST_VAL(1'b1)) u_sel (
            .xclk(xclk), .rst(rst), .i_d(sel_n[g]),
            .o_q(w_sel_q[g]), .o_rise(w_sel_rise[g]), .o_fall(w_sel_fall[g])
        );
        fdd_sync_edge #(.RST_VAL(1'b0)) u_ena (
            .xclk(xclk), .rst(rst), .i_d(ena[g]),
            .o_q(w_ena_q[g]), .o_rise(w_ena_rise[g]), .o_fall(w_ena_fall[g])
        );
    end

    fdd_sync_edge #(.RST_VAL(1'b1)) u_mtr_n (
        .xclk(xclk), .rst(rst), .i_d(mtr_n),
        .o_q(w_mtr_n_q), .o_rise(w_mtr_n_rise), .o_fall(w_mtr_n_fall)
    );
    fdd_sync_edge #(.RST_VAL(1'b0)) u_dir (
        .xclk(xclk), .rst(rst), .i_d(dir),
        .o_q(w_dir_q), .o_rise(w_dir_rise), .o_fall(w_dir_fall)
    );
    fdd_sync_edge #(.RST_VAL(1'b1)) u_step (
        .xclk(xclk), .rst(rst), .i_d(step_n),
        .o_q(w_step_q), .o_rise(w_step_rise), .o_fall(w_step_fall)
    );
    fdd_sync_edge #(.RST_VAL(1'b0)) u_side (
        .xclk(xclk), .rst(rst), .i_d(side),
        .o_q(w_side_q), .o_rise(w_side_rise), .o_fall(w_side_fall)
    );

    logic [CYL_W-1:0]      r_cyl [NUM_DRIVES];
    logic [NUM_DRIVES-1:0] r_trk0_n;
    logic [NUM_DRIVES-1:0] r_mtr_on;
    logic [31:0]           r_idx_cnt;
    logic                  r_index_n;
    logic [1:0]            r_state;
    logic [31:0]           r_timer;
    logic [1:0]            r_drive;
    logic                  r_pending;
    logic [1:0]            r_pend_drive;
    logic                  r_req_valid;
    logic [1:0]            r_req_drive;
    logic [CYL_W-1:0]      r_req_cyl;
    logic                  r_req_side;

    logic [NUM_DRIVES-1:0] w_active;
    logic [NUM_DRIVES-1:0] w_moved;
    logic                  w_event;
    logic [1:0]            w_first;
    logic                  w_motor_any;

    assign w_active    = ~w_sel_q & w_ena_q;
    assign w_first     = first_active(w_active);
    assign w_motor_any = |(r_mtr_on & w_ena_q);

    // Which active slots actually move on this step (saturated steps do not count)
    always_comb begin
        w_moved = '0;
        for (int i = 0; i < NUM_DRIVES; i++) begin
            if (w_step_rise && w_active[i]) begin
                w_moved[i] = w_dir_q ? (r_cyl[i] != '0) : (r_cyl[i] != L_MAX_CYL);
            end
        end
    end

    assign w_event = (|w_moved) | ((w_side_rise | w_side_fall) & (|w_active));

    // Head position per slot and registered TRK0 indication
    always_ff @(posedge xclk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_DRIVES; i++) r_cyl[i] <= '0;
            r_trk0_n <= '0;
        end else begin
            for (int i = 0; i < NUM_DRIVES; i++) begin
                if (w_moved[i]) begin
                    r_cyl[i] <= w_dir_q ? r_cyl[i] - 1'b1 : r_cyl[i] + 1'b1;
                end
                r_trk0_n[i] <= (r_cyl[i] != '0);
            end
        end
    end

    // Motor latch on select falling edge; a disabled slot always reads motor off
    always_ff @(posedge xclk or posedge rst) begin
        if (rst) begin
            r_mtr_on <= '0;
        end else begin
            for (int i = 0; i < NUM_DRIVES; i++) begin
                if (!w_ena_q[i]) r_mtr_on[i] <= 1'b0;
                else if (w_sel_fall[i]) r_mtr_on[i] <= ~w_mtr_n_q;
            end
        end
    end

    // Shared revolution counter; cleared while no motor spins so the next
    // spin-up starts with the index pulse
    always_ff @(posedge xclk or posedge rst) begin
        if (rst) begin
            r_idx_cnt <= '0;
            r_index_n <= 1'b1;
        end else if (!w_motor_any) begin
            r_idx_cnt <= '0;
            r_index_n <= 1'b1;
        end else begin
            r_index_n <= (r_idx_cnt >= L_IDX_WIDTH);
            r_idx_cnt <= (r_idx_cnt == L_IDX_LAST) ? '0 : r_idx_cnt + 1'b1;
        end
    end

    // Track-load request sequencing with settle down-counter
    always_ff @(posedge xclk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_timer      <= '0;
            r_drive      <= '0;
            r_pending    <= 1'b0;
            r_pend_drive <= '0;
            r_req_valid  <= 1'b0;
            r_req_drive  <= '0;
            r_req_cyl    <= '0;
            r_req_side   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_event) begin
                        r_drive <= w_first;
                        r_timer <= L_SETTLE;
                        r_state <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (w_event) begin
                        r_drive <= w_first;
                        r_timer <= L_SETTLE;
                    end else if (!w_ena_q[r_drive]) begin
                        r_state <= S_IDLE;
                    end else if (r_timer == '0) begin
                        r_req_drive <= r_drive;
                        r_req_cyl   <= r_cyl[r_drive];
                        r_req_side  <= w_side_q;
                        r_req_valid <= 1'b1;
                        r_state     <= S_REQ;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                S_REQ: begin
                    if (w_event) begin
                        r_pending    <= 1'b1;
                        r_pend_drive <= w_first;
                    end
                    if (r_req_valid && req_ack) begin
                        r_req_valid <= 1'b0;
                        r_pending   <= 1'b0;
                        if (r_pending || w_event) begin
                            r_drive <= w_event ? w_first : r_pend_drive;
                            r_timer <= L_SETTLE;
                            r_state <= S_SETTLE;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign trk0_n    = r_trk0_n;
    assign mtr_on    = r_mtr_on;
    assign index_n   = r_index_n;
    assign req_valid = r_req_valid;
    assign req_drive = r_req_drive;
    assign req_cyl   = r_req_cyl;
    assign req_side  = r_req_side;

endmodule

// File: tb/tb_fdd_head_sequencer.sv
// Scoreboard bench for fdd_head_sequencer with shortened timing constants.
module tb_fdd_head_sequencer;

    localparam int MAX_CYL = 83;
    localparam int PERIOD  = 100;
    localparam int WIDTH   = 10;
    localparam int SETTLE  = 20;

    typedef struct packed {
        logic [1:0] drv;
        logic [6:0] cyl;
        logic       side;
    } req_t;

    logic       xclk = 1'b0;
    logic       rst;
    logic [3:0] sel_n;
    logic [3:0] ena;
    logic       mtr_n;
    logic       dir;
    logic       step_n;
    logic       side;
    logic [3:0] trk0_n;
    logic [3:0] mtr_on;
    logic       index_n;
    logic       req_valid;
    logic [1:0] req_drive;
    logic [6:0] req_cyl;
    logic       req_side;
    logic       req_ack;

    int total = 0;
    int bad   = 0;
    req_t exp_q[$];

    fdd_head_sequencer #(
        .MAX_CYL(MAX_CYL), .INDEX_PERIOD(PERIOD),
        .INDEX_WIDTH(WIDTH), .SETTLE_CYCLES(SETTLE)
    ) dut (
        .xclk(xclk), .rst(rst), .sel_n(sel_n), .ena(ena), .mtr_n(mtr_n),
        .dir(dir), .step_n(step_n), .side(side), .trk0_n(trk0_n),
        .mtr_on(mtr_on), .index_n(index_n), .req_valid(req_valid),
        .req_drive(req_drive), .req_cyl(req_cyl), .req_side(req_side),
        .req_ack(req_ack)
    );

    always #5 xclk = ~xclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge xclk);
        #1;
    endtask

    task automatic do_step();
        step_n = 1'b0;
        repeat (3) @(posedge xclk);
        step_n = 1'b1;
        repeat (3) @(posedge xclk);
        #1;
    endtask

    task automatic wait_req(input string name);
        int n;
        n = 0;
        while (req_valid !== 1'b1 && n < 200) begin
            @(negedge xclk);
            n++;
        end
        total++;
        if (req_valid !== 1'b1) begin
            bad++;
            $display("FAIL %s: req_valid got %b expected 1 within 200 cycles", name, req_valid);
        end
    endtask

    task automatic ack_req(input string name);
        wait_req(name);
        @(negedge xclk);
        req_ack = 1'b1;
        @(posedge xclk);
        #1;
        chk({name, "_drop"}, 32'(req_valid), 32'd0);
        req_ack = 1'b0;
    endtask

    // Monitor: pop and compare on each new request, then check it stays stable
    initial begin
        logic seen;
        req_t snap;
        req_t e;
        seen = 1'b0;
        forever begin
            @(negedge xclk);
            if (rst === 1'b1 || req_valid !== 1'b1) begin
                seen = 1'b0;
            end else if (!seen) begin
                seen = 1'b1;
                snap = '{drv: req_drive, cyl: req_cyl, side: req_side};
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_req: got drv=%0d cyl=%0d side=%0d expected none",
                             req_drive, req_cyl, req_side);
                end else begin
                    e = exp_q.pop_front();
                    if (snap !== e) begin
                        bad++;
                        $display("FAIL req_fields: got drv=%0d cyl=%0d side=%0d expected drv=%0d cyl=%0d side=%0d",
                                 snap.drv, snap.cyl, snap.side, e.drv, e.cyl, e.side);
                    end
                end
            end else begin
                total++;
                if ({req_drive, req_cyl, req_side} !== snap) begin
                    bad++;
                    $display("FAIL req_hold: got %0h expected %0h",
                             {req_drive, req_cyl, req_side}, snap);
                end
            end
        end
    end

    initial begin
        int lowcnt;
        int highcnt;
        rst = 1'b1; sel_n = 4'b1111; ena = 4'b0001; mtr_n = 1'b1; dir = 1'b0;
        step_n = 1'b1; side = 1'b0; req_ack = 1'b0;
        cycles(3);
        chk("rst_trk0", 32'(trk0_n), 32'h0);
        chk("rst_mtr", 32'(mtr_on), 32'h0);
        chk("rst_index", 32'(index_n), 32'd1);
        chk("rst_valid", 32'(req_valid), 32'd0);
        chk("rst_fields", 32'({req_drive, req_cyl, req_side}), 32'h0);
        rst = 1'b0;

        // Three steps in on slot 0
        sel_n = 4'b1110;
        cycles(5);
        for (int i = 0; i < 3; i++) do_step();
        cycles(3);
        chk("t1_trk0", 32'(trk0_n[0]), 32'd1);
        chk("t1_no_early_req", 32'(req_valid), 32'd0);
        exp_q.push_back('{drv: 2'd0, cyl: 7'd3, side: 1'b0});
        ack_req("t1");

        // Saturation at MAX_CYL on slot 1, then back to track 0
        sel_n = 4'b1111; ena = 4'b0010;
        cycles(4);
        sel_n = 4'b1101;
        cycles(4);
        exp_q.push_back('{drv: 2'd1, cyl: 7'(MAX_CYL), side: 1'b0});
        for (int i = 0; i < 90; i++) do_step();
        ack_req("t2_max");
        do_step();
        cycles(3 * SETTLE);
        chk("t2_sat_no_req", 32'(req_valid), 32'd0);
        dir = 1'b1;
        cycles(4);
        for (int i = 0; i < MAX_CYL - 1; i++) do_step();
        cycles(2);
        chk("t2_trk0_cyl1", 32'(trk0_n[1]), 32'd1);
        exp_q.push_back('{drv: 2'd1, cyl: 7'd0, side: 1'b0});
        do_step();
        cycles(2);
        chk("t2_trk0_cyl0", 32'(trk0_n[1]), 32'd0);
        ack_req("t2_zero");

        // Step and side change during REQ are held off until ack
        sel_n = 4'b1111; ena = 4'b1000; dir = 1'b0;
        cycles(4);
        sel_n = 4'b0111;
        cycles(4);
        exp_q.push_back('{drv: 2'd3, cyl: 7'd2, side: 1'b0});
        do_step();
        do_step();
        wait_req("t4_first");
        do_step();
        side = 1'b1;
        cycles(5);
        chk("t4_hold", 32'({req_valid, req_drive, req_cyl, req_side}),
            32'({1'b1, 2'd3, 7'd2, 1'b0}));
        exp_q.push_back('{drv: 2'd3, cyl: 7'd3, side: 1'b1});
        ack_req("t4_ack1");
        ack_req("t4_second");
        sel_n = 4'b1111;
        cycles(4);
        side = 1'b0;
        cycles(4);

        // Motor latch and index generation on slot 2
        mtr_n = 1'b0; ena = 4'b0100;
        cycles(4);
        sel_n = 4'b1011;
        lowcnt = 0;
        while (mtr_on[2] !== 1'b1 && lowcnt < 20) begin
            @(negedge xclk);
            lowcnt++;
        end
        chk("t3_mtr_on", 32'(mtr_on), 32'b0100);
        @(negedge xclk);
        chk("t3_index_start", 32'(index_n), 32'd0);
        lowcnt = 0;
        while (index_n === 1'b0 && lowcnt < 2 * PERIOD) begin
            lowcnt++;
            @(negedge xclk);
        end
        highcnt = 0;
        while (index_n === 1'b1 && highcnt < 2 * PERIOD) begin
            highcnt++;
            @(negedge xclk);
        end
        chk("t3_index_width", 32'(lowcnt), 32'(WIDTH));
        chk("t3_index_period", 32'(lowcnt + highcnt), 32'(PERIOD));
        ena = 4'b0000;
        cycles(5);
        chk("t3_off_index", 32'(index_n), 32'd1);
        chk("t3_off_mtr", 32'(mtr_on), 32'h0);
        ena = 4'b0100;
        cycles(5);
        chk("t3_reena_no_latch", 32'(mtr_on), 32'h0);
        chk("t3_reena_index", 32'(index_n), 32'd1);
        sel_n = 4'b1111;
        cycles(4);
        sel_n = 4'b1011;
        lowcnt = 0;
        while (mtr_on[2] !== 1'b1 && lowcnt < 20) begin
            @(negedge xclk);
            lowcnt++;
        end
        chk("t3_relatch", 32'(mtr_on[2]), 32'd1);
        @(negedge xclk);
        chk("t3_restart_index", 32'(index_n), 32'd0);
        ena = 4'b0000; mtr_n = 1'b1; sel_n = 4'b1111;
        cycles(5);

        // Step on a selected but disabled slot is ignored
        sel_n = 4'b1110;
        cycles(4);
        do_step();
        do_step();
        cycles(3 * SETTLE);
        chk("t5_no_req", 32'(req_valid), 32'd0);
        chk("t5_trk0", 32'(trk0_n), 32'b1001);
        ena = 4'b0001; dir = 1'b1;
        cycles(4);
        exp_q.push_back('{drv: 2'd0, cyl: 7'd2, side: 1'b0});
        do_step();
        ack_req("t5_cyl");

        // Reset during SETTLE at cylinder 10 with a motor spinning
        sel_n = 4'b1111; mtr_n = 1'b0; dir = 1'b0;
        cycles(4);
        sel_n = 4'b1110;
        cycles(4);
        for (int i = 0; i < 8; i++) do_step();
        cycles(2);
        chk("t6_settle_no_req", 32'(req_valid), 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_valid", 32'(req_valid), 32'd0);
        chk("t6_rst_index", 32'(index_n), 32'd1);
        chk("t6_rst_trk0", 32'(trk0_n), 32'h0);
        chk("t6_rst_mtr", 32'(mtr_on), 32'h0);
        mtr_n = 1'b1;
        cycles(3);
        rst = 1'b0;
        cycles(3 * SETTLE);
        chk("t6_no_spurious", 32'(req_valid), 32'd0);
        exp_q.push_back('{drv: 2'd0, cyl: 7'd1, side: 1'b0});
        do_step();
        ack_req("t6_after_rst");
        cycles(3);
        chk("t6_trk0", 32'(trk0_n), 32'b0001);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time limit so the run can never hang
    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit, expected completion");
        $fatal(1, "timeout");
    end

endmodule
